// File: rtl/pps_timekeeper_if.sv
// Bundle of PPS strobe, seconds-load request and timekeeping outputs.
// slave = timekeeper side, master = consumer/driver side.
interface pps_timekeeper_if;
    logic        pps_in;
    logic        sec_load_valid;
    logic [31:0] sec_load_value;
    logic        tick;
    logic [31:0] sec_count;
    logic [31:0] subsec_count;
    logic [31:0] period_last;
    logic [1:0]  state;
    logic        pps_missing;
    logic        pps_err;

    modport slave (
        input  pps_in, sec_load_valid, sec_load_value,
        output tick, sec_count, subsec_count, period_last,
        output state, pps_missing, pps_err
    );

    modport master (
        output pps_in, sec_load_valid, sec_load_value,
        input  tick, sec_count, subsec_count, period_last,
        input  state, pps_missing, pps_err
    );
endinterface

// File: rtl/pps_timekeeper.sv
// 1PPS-disciplined seconds/sub-second timekeeper with lock tracking.
// Define PPS_TIMEKEEPER_HOLDOVER_EN to freewheel after a lost lock.
module pps_timekeeper #(
    parameter int unsigned C_CLOCK_FREQUENCY = 125000000,
    parameter int unsigned C_TOLERANCE       = 100,
    parameter int unsigned C_LOCK_COUNT      = 3
) (
    input logic              clk,
    input logic              rst,
    pps_timekeeper_if.slave  bus
);
    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2,
        HOLDOVER = 2'd3
    } state_t;

    localparam int unsigned LW = $clog2(C_LOCK_COUNT + 1);
    localparam logic [31:0] F_LO = 32'(C_CLOCK_FREQUENCY - C_TOLERANCE);
    localparam logic [31:0] F_HI = 32'(C_CLOCK_FREQUENCY + C_TOLERANCE);
    localparam logic [31:0] F_M1 = 32'(C_CLOCK_FREQUENCY - 1);
    localparam logic [31:0] CMAX = '1;
    localparam logic [LW-1:0] LOCK_N = LW'(C_LOCK_COUNT);

    state_t      state_q, state_d;
    logic [31:0] sec_q, sec_d;
    logic [31:0] sub_q, sub_d;
    logic [31:0] per_q, per_d;
    logic [31:0] pcnt_q, pcnt_d;
    logic [LW-1:0] lock_q, lock_d;
    logic        tick_q, tick_d;
    logic        miss_q, miss_d;
    logic        err_q, err_d;
    logic        pend_q, pend_d;
    logic [31:0] pval_q, pval_d;

    logic [31:0] period;
    logic [31:0] sub_sat;
    logic [LW-1:0] lock_inc;
    logic        pps;
    logic        valid;
    logic        timeout;

    always_comb begin
        pps      = bus.pps_in;
        period   = (pcnt_q == CMAX) ? CMAX : pcnt_q + 32'd1;
        valid    = (period >= F_LO) && (period <= F_HI);
        timeout  = (pcnt_q >= F_HI) && !pps;
        sub_sat  = (sub_q >= F_M1) ? F_M1 : sub_q + 32'd1;
        lock_inc = lock_q + LW'(1);

        state_d = state_q;
        sub_d   = sub_q;
        per_d   = per_q;
        lock_d  = lock_q;
        tick_d  = 1'b0;
        miss_d  = 1'b0;
        err_d   = 1'b0;
        pcnt_d  = pps ? 32'd0 : period;

        case (state_q)
            UNLOCKED: begin
                sub_d = '0;
                if (pps) begin
                    state_d = ACQUIRE;
                    lock_d  = '0;
                    tick_d  = 1'b1;
                end
            end
            ACQUIRE: begin
                if (pps) begin
                    tick_d = 1'b1;
                    sub_d  = '0;
                    per_d  = period;
                    if (valid) begin
                        lock_d = lock_inc;
                        if (lock_inc >= LOCK_N) state_d = LOCKED;
                    end else begin
                        err_d  = 1'b1;
                        lock_d = '0;
                    end
                end else if (timeout) begin
                    state_d = UNLOCKED;
                    miss_d  = 1'b1;
                    sub_d   = '0;
                    lock_d  = '0;
                end else begin
                    sub_d = sub_sat;
                end
            end
            LOCKED: begin
                if (pps) begin
                    tick_d = 1'b1;
                    sub_d  = '0;
                    per_d  = period;
                    if (!valid) begin
                        err_d   = 1'b1;
                        state_d = ACQUIRE;
                        lock_d  = '0;
                    end
                end else if (timeout) begin
                    miss_d = 1'b1;
                    lock_d = '0;
`ifdef PPS_TIMEKEEPER_HOLDOVER_EN
                    state_d = HOLDOVER;
                    sub_d   = sub_sat;
`else
                    state_d = UNLOCKED;
                    sub_d   = '0;
`endif
                end else begin
                    sub_d = sub_sat;
                end
            end
`ifdef PPS_TIMEKEEPER_HOLDOVER_EN
            HOLDOVER: begin
                if (pps) begin
                    state_d = ACQUIRE;
                    lock_d  = '0;
                    tick_d  = 1'b1;
                    sub_d   = '0;
                    per_d   = period;
                end else if (sub_q >= F_M1) begin
                    sub_d  = '0;
                    tick_d = 1'b1;
                end else begin
                    sub_d = sub_q + 32'd1;
                end
            end
`endif
            default: begin
                state_d = UNLOCKED;
                sub_d   = '0;
                lock_d  = '0;
            end
        endcase

        // A load arriving with the tick is held for the next one.
        pval_d = bus.sec_load_valid ? bus.sec_load_value : pval_q;
        sec_d  = sec_q;
        if (tick_d) begin
            sec_d  = pend_q ? pval_q : sec_q + 32'd1;
            pend_d = bus.sec_load_valid;
        end else begin
            pend_d = pend_q | bus.sec_load_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= UNLOCKED;
            sec_q   <= '0;
            sub_q   <= '0;
            per_q   <= '0;
            pcnt_q  <= '0;
            lock_q  <= '0;
            tick_q  <= 1'b0;
            miss_q  <= 1'b0;
            err_q   <= 1'b0;
            pend_q  <= 1'b0;
            pval_q  <= '0;
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            sub_q   <= sub_d;
            per_q   <= per_d;
            pcnt_q  <= pcnt_d;
            lock_q  <= lock_d;
            tick_q  <= tick_d;
            miss_q  <= miss_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
            pval_q  <= pval_d;
        end
    end

    assign bus.tick         = tick_q;
    assign bus.sec_count    = sec_q;
    assign bus.subsec_count = sub_q;
    assign bus.period_last  = per_q;
    assign bus.state        = state_q;
    assign bus.pps_missing  = miss_q;
    assign bus.pps_err      = err_q;
endmodule

// File: tb/tb_pps_timekeeper.sv
// Directed bench for pps_timekeeper with F=1000, T=10, N=3.
// Covers both builds via PPS_TIMEKEEPER_HOLDOVER_EN.
module tb_pps_timekeeper;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    logic [31:0] es = 32'd0;

    pps_timekeeper_if bus ();

    pps_timekeeper #(
        .C_CLOCK_FREQUENCY(1000),
        .C_TOLERANCE(10),
        .C_LOCK_COUNT(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int gap);
        repeat (gap - 1) step();
        bus.pps_in = 1'b1;
        step();
        bus.pps_in = 1'b0;
    endtask

    task automatic pulse_load(input int gap, input logic [31:0] v);
        repeat (gap - 1) step();
        bus.pps_in = 1'b1;
        bus.sec_load_valid = 1'b1;
        bus.sec_load_value = v;
        step();
        bus.pps_in = 1'b0;
        bus.sec_load_valid = 1'b0;
    endtask

    task automatic load_step(input logic [31:0] v);
        bus.sec_load_valid = 1'b1;
        bus.sec_load_value = v;
        step();
        bus.sec_load_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.pps_in = 1'b1;
        repeat (3) step();
        bus.pps_in = 1'b0;
        total++; if (bus.state !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", bus.state); end
        total++; if (bus.tick !== 1'b0) begin bad++; $display("FAIL rst_tick got=%0b exp=0", bus.tick); end
        total++; if (bus.sec_count !== 32'd0) begin bad++; $display("FAIL rst_sec got=%0h exp=0", bus.sec_count); end
        total++; if (bus.subsec_count !== 32'd0) begin bad++; $display("FAIL rst_sub got=%0h exp=0", bus.subsec_count); end
        total++; if (bus.period_last !== 32'd0) begin bad++; $display("FAIL rst_per got=%0h exp=0", bus.period_last); end
        total++; if ({bus.pps_missing, bus.pps_err} !== 2'b00) begin bad++; $display("FAIL rst_flags got=%0b exp=0", {bus.pps_missing, bus.pps_err}); end
        rst = 1'b0;
        repeat (5) step();
        total++; if (bus.subsec_count !== 32'd0) begin bad++; $display("FAIL unl_sub got=%0h exp=0", bus.subsec_count); end
    endtask

    task automatic test_acquire_lock();
        logic [1:0]  exp_st [4] = '{2'd1, 2'd1, 2'd1, 2'd2};
        logic [31:0] exp_per [4] = '{32'd0, 32'd1000, 32'd1000, 32'd1000};
        for (int i = 0; i < 4; i++) begin
            pulse(i == 0 ? 500 : 1000);
            es = es + 32'd1;
            total++; if (bus.state !== exp_st[i]) begin bad++; $display("FAIL acq_state%0d got=%0d exp=%0d", i, bus.state, exp_st[i]); end
            total++; if (bus.tick !== 1'b1) begin bad++; $display("FAIL acq_tick%0d got=%0b exp=1", i, bus.tick); end
            total++; if (bus.period_last !== exp_per[i]) begin bad++; $display("FAIL acq_per%0d got=%0d exp=%0d", i, bus.period_last, exp_per[i]); end
            total++; if (bus.sec_count !== es) begin bad++; $display("FAIL acq_sec%0d got=%0h exp=%0h", i, bus.sec_count, es); end
        end
        step();
        total++; if (bus.tick !== 1'b0) begin bad++; $display("FAIL acq_single_tick got=%0b exp=0", bus.tick); end
        total++; if (bus.subsec_count !== 32'd1) begin bad++; $display("FAIL acq_sub got=%0d exp=1", bus.subsec_count); end
    endtask

    task automatic test_period_err();
        pulse(999);
        es = es + 32'd1;
        total++; if (bus.state !== 2'd2) begin bad++; $display("FAIL lk_state got=%0d exp=2", bus.state); end
        pulse(985);
        es = es + 32'd1;
        total++; if (bus.pps_err !== 1'b1) begin bad++; $display("FAIL err_pulse got=%0b exp=1", bus.pps_err); end
        total++; if (bus.state !== 2'd1) begin bad++; $display("FAIL err_state got=%0d exp=1", bus.state); end
        total++; if (bus.tick !== 1'b1) begin bad++; $display("FAIL err_tick got=%0b exp=1", bus.tick); end
        total++; if (bus.period_last !== 32'd985) begin bad++; $display("FAIL err_per got=%0d exp=985", bus.period_last); end
        total++; if (bus.sec_count !== es) begin bad++; $display("FAIL err_sec got=%0h exp=%0h", bus.sec_count, es); end
        step();
        total++; if (bus.pps_err !== 1'b0) begin bad++; $display("FAIL err_one_cycle got=%0b exp=0", bus.pps_err); end
        pulse(989);
        es = es + 32'd1;
        total++; if ({bus.pps_err, bus.state} !== 3'b001) begin bad++; $display("FAIL lo_edge got=%0b exp=001", {bus.pps_err, bus.state}); end
        pulse(1010);
        es = es + 32'd1;
        total++; if ({bus.pps_err, bus.state} !== 3'b001) begin bad++; $display("FAIL hi_edge got=%0b exp=001", {bus.pps_err, bus.state}); end
        pulse(1000);
        es = es + 32'd1;
        total++; if (bus.state !== 2'd2) begin bad++; $display("FAIL relock got=%0d exp=2", bus.state); end
    endtask

    task automatic test_coincident_timeout();
        pulse(1011);
        es = es + 32'd1;
        total++; if (bus.pps_missing !== 1'b0) begin bad++; $display("FAIL co_missing got=%0b exp=0", bus.pps_missing); end
        total++; if (bus.pps_err !== 1'b1) begin bad++; $display("FAIL co_err got=%0b exp=1", bus.pps_err); end
        total++; if (bus.state !== 2'd1) begin bad++; $display("FAIL co_state got=%0d exp=1", bus.state); end
        total++; if (bus.period_last !== 32'd1011) begin bad++; $display("FAIL co_per got=%0d exp=1011", bus.period_last); end
        repeat (3) pulse(1000);
        es = es + 32'd3;
        total++; if (bus.state !== 2'd2) begin bad++; $display("FAIL co_relock got=%0d exp=2", bus.state); end
    endtask

    task automatic test_sec_load();
        repeat (400) step();
        load_step(32'hFFFF_FFFF);
        total++; if (bus.sec_count !== es) begin bad++; $display("FAIL ld_hold got=%0h exp=%0h", bus.sec_count, es); end
        pulse(599);
        total++; if (bus.sec_count !== 32'hFFFF_FFFF) begin bad++; $display("FAIL ld_apply got=%0h exp=ffffffff", bus.sec_count); end
        pulse_load(1000, 32'h1234_5678);
        total++; if (bus.sec_count !== 32'd0) begin bad++; $display("FAIL ld_wrap got=%0h exp=0", bus.sec_count); end
        pulse(1000);
        total++; if (bus.sec_count !== 32'h1234_5678) begin bad++; $display("FAIL ld_coinc got=%0h exp=12345678", bus.sec_count); end
        repeat (100) step();
        load_step(32'h0000_AAAA);
        repeat (100) step();
        load_step(32'h0000_5555);
        pulse(798);
        total++; if (bus.sec_count !== 32'h0000_5555) begin bad++; $display("FAIL ld_overwrite got=%0h exp=5555", bus.sec_count); end
        pulse(1000);
        total++; if (bus.sec_count !== 32'h0000_5556) begin bad++; $display("FAIL ld_cleared got=%0h exp=5556", bus.sec_count); end
        es = 32'h0000_5556;
    endtask

    task automatic test_holdover();
        int nt;
        repeat (1010) step();
        total++; if ({bus.pps_missing, bus.state} !== 3'b010) begin bad++; $display("FAIL to_pre got=%0b exp=010", {bus.pps_missing, bus.state}); end
        total++; if (bus.subsec_count !== 32'd999) begin bad++; $display("FAIL to_sat got=%0d exp=999", bus.subsec_count); end
        step();
        total++; if (bus.pps_missing !== 1'b1) begin bad++; $display("FAIL to_missing got=%0b exp=1", bus.pps_missing); end
`ifdef PPS_TIMEKEEPER_HOLDOVER_EN
        total++; if (bus.state !== 2'd3) begin bad++; $display("FAIL ho_state got=%0d exp=3", bus.state); end
        step();
        es = es + 32'd1;
        total++; if ({bus.tick, bus.pps_missing} !== 2'b10) begin bad++; $display("FAIL ho_tick1 got=%0b exp=10", {bus.tick, bus.pps_missing}); end
        total++; if (bus.sec_count !== es) begin bad++; $display("FAIL ho_sec1 got=%0h exp=%0h", bus.sec_count, es); end
        nt = 0;
        repeat (999) begin step(); nt += int'(bus.tick); end
        total++; if (nt != 0 || bus.subsec_count !== 32'd999) begin bad++; $display("FAIL ho_gap got=%0d/%0d exp=0/999", nt, bus.subsec_count); end
        step();
        es = es + 32'd1;
        total++; if (bus.tick !== 1'b1 || bus.subsec_count !== 32'd0) begin bad++; $display("FAIL ho_tick2 got=%0b/%0d exp=1/0", bus.tick, bus.subsec_count); end
        total++; if (bus.sec_count !== es) begin bad++; $display("FAIL ho_sec2 got=%0h exp=%0h", bus.sec_count, es); end
        pulse(488);
        es = es + 32'd1;
        total++; if (bus.state !== 2'd1 || bus.tick !== 1'b1) begin bad++; $display("FAIL ho_exit got=%0d/%0b exp=1/1", bus.state, bus.tick); end
        total++; if (bus.period_last !== 32'd2500) begin bad++; $display("FAIL ho_per got=%0d exp=2500", bus.period_last); end
`else
        total++; if (bus.state !== 2'd0) begin bad++; $display("FAIL nh_state got=%0d exp=0", bus.state); end
        total++; if (bus.subsec_count !== 32'd0) begin bad++; $display("FAIL nh_sub got=%0d exp=0", bus.subsec_count); end
        nt = 0;
        repeat (1001) begin step(); nt += int'(bus.tick); end
        total++; if (nt != 0 || bus.state !== 2'd0) begin bad++; $display("FAIL nh_ticks got=%0d/%0d exp=0/0", nt, bus.state); end
        pulse(488);
        es = es + 32'd1;
        total++; if (bus.state !== 2'd1 || bus.tick !== 1'b1) begin bad++; $display("FAIL nh_exit got=%0d/%0b exp=1/1", bus.state, bus.tick); end
        total++; if (bus.period_last !== 32'd1000) begin bad++; $display("FAIL nh_per got=%0d exp=1000", bus.period_last); end
`endif
        total++; if (bus.sec_count !== es) begin bad++; $display("FAIL rl_sec got=%0h exp=%0h", bus.sec_count, es); end
        repeat (3) pulse(1000);
        total++; if (bus.state !== 2'd2) begin bad++; $display("FAIL rl_state got=%0d exp=2", bus.state); end
    endtask

    task automatic test_reset_mid();
        repeat (10) step();
        rst = 1'b1;
        bus.pps_in = 1'b1;
        bus.sec_load_valid = 1'b1;
        bus.sec_load_value = 32'h77;
        step();
        rst = 1'b0;
        bus.pps_in = 1'b0;
        bus.sec_load_valid = 1'b0;
        total++; if ({bus.tick, bus.pps_missing, bus.pps_err, bus.state} !== 5'b0) begin bad++; $display("FAIL mr_flags got=%0b exp=0", {bus.tick, bus.pps_missing, bus.pps_err, bus.state}); end
        total++; if ({bus.sec_count, bus.subsec_count, bus.period_last} !== 96'd0) begin bad++; $display("FAIL mr_counts got=%0h/%0h/%0h exp=0", bus.sec_count, bus.subsec_count, bus.period_last); end
        pulse(1000);
        total++; if (bus.state !== 2'd1 || bus.tick !== 1'b1) begin bad++; $display("FAIL mr_acq got=%0d/%0b exp=1/1", bus.state, bus.tick); end
        total++; if (bus.sec_count !== 32'd1) begin bad++; $display("FAIL mr_noload got=%0h exp=1", bus.sec_count); end
        total++; if (bus.period_last !== 32'd0) begin bad++; $display("FAIL mr_per got=%0d exp=0", bus.period_last); end
    endtask

    initial begin
        bus.pps_in = 1'b0;
        bus.sec_load_valid = 1'b0;
        bus.sec_load_value = 32'd0;
        test_reset();
        test_acquire_lock();
        test_period_err();
        test_coincident_timeout();
        test_sec_load();
        test_holdover();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
